// File: rtl/intdiv_otf_conv.sv
// On-the-fly converter: SD2 quotient digits (MSB first) into an N+1 bit two's-complement integer.
// Q and QM = Q-1 are kept side by side so every digit is a shift plus LSB fill, with no carry chain.
module intdiv_otf_conv #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         dig_valid,
    input  logic [1:0]   dig,
    output logic         dig_ready,
    output logic         busy,
    output logic         q_valid,
    output logic [N:0]   q
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [N:0]      q_acc_r;
    logic [N:0]      qm_acc_r;
    logic [CW-1:0]   count_r;
    logic            dig_ready_r;
    logic            busy_r;
    logic            q_valid_r;
    logic [N:0]      q_out_r;

    logic [N:0]      q_shift_s;
    logic [N:0]      qm_shift_s;
    logic            accept_s;
    logic            last_s;

    // Both 01 and 10 encode +1.
    function automatic logic dig_is_pos(input logic [1:0] d);
        return (d == 2'b01) || (d == 2'b10);
    endfunction

    function automatic logic dig_is_neg(input logic [1:0] d);
        return (d == 2'b11);
    endfunction

    assign accept_s = dig_valid && dig_ready_r && (state_r == ST_CONV);
    assign last_s   = (count_r == CW'(N - 1));

    // Shift-and-fill selection of the next Q / QM pair for the presented digit.
    always_comb begin
        q_shift_s  = {q_acc_r[N-1:0], 1'b0};
        qm_shift_s = {qm_acc_r[N-1:0], 1'b1};
        if (dig_is_pos(dig)) begin
            q_shift_s  = {q_acc_r[N-1:0], 1'b1};
            qm_shift_s = {q_acc_r[N-1:0], 1'b0};
        end else if (dig_is_neg(dig)) begin
            q_shift_s  = {qm_acc_r[N-1:0], 1'b1};
            qm_shift_s = {qm_acc_r[N-1:0], 1'b0};
        end else begin
            q_shift_s  = {q_acc_r[N-1:0], 1'b0};
            qm_shift_s = {qm_acc_r[N-1:0], 1'b1};
        end
    end

    // Conversion FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            q_acc_r     <= '0;
            qm_acc_r    <= '1;
            count_r     <= '0;
            dig_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            q_valid_r   <= 1'b0;
            q_out_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // A digit arriving with start is ignored: dig_ready is still low here.
                    if (start) begin
                        state_r     <= ST_CONV;
                        q_acc_r     <= '0;
                        qm_acc_r    <= '1;
                        count_r     <= '0;
                        dig_ready_r <= 1'b1;
                        busy_r      <= 1'b1;
                        q_valid_r   <= 1'b0;
                        q_out_r     <= '0;
                    end else begin
                        state_r     <= state_r;
                    end
                end
                ST_CONV: begin
                    if (accept_s) begin
                        q_acc_r  <= q_shift_s;
                        qm_acc_r <= qm_shift_s;
                        if (last_s) begin
                            state_r     <= ST_DONE;
                            count_r     <= '0;
                            dig_ready_r <= 1'b0;
                            busy_r      <= 1'b0;
                            q_valid_r   <= 1'b1;
                            q_out_r     <= q_shift_s;
                        end else begin
                            count_r     <= count_r + CW'(1);
                        end
                    end else begin
                        count_r <= count_r;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    q_acc_r     <= '0;
                    qm_acc_r    <= '1;
                    count_r     <= '0;
                    dig_ready_r <= 1'b0;
                    busy_r      <= 1'b0;
                    q_valid_r   <= 1'b0;
                    q_out_r     <= '0;
                end
            endcase
        end
    end

    assign dig_ready = dig_ready_r;
    assign busy      = busy_r;
    assign q_valid   = q_valid_r;
    assign q         = q_out_r;

endmodule

// File: tb/tb_intdiv_otf_conv.sv
// Directed bench for intdiv_otf_conv with N=4; expected results are hand-computed digit-string values.
module tb_intdiv_otf_conv;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         dig_valid;
    logic [1:0]   dig;
    logic         dig_ready;
    logic         busy;
    logic         q_valid;
    logic [N:0]   q;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [1:0] P1 = 2'b01;
    localparam logic [1:0] P2 = 2'b10;
    localparam logic [1:0] Z0 = 2'b00;
    localparam logic [1:0] M1 = 2'b11;

    always #5 clk = ~clk;

    intdiv_otf_conv #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dig_valid (dig_valid),
        .dig       (dig),
        .dig_ready (dig_ready),
        .busy      (busy),
        .q_valid   (q_valid),
        .q         (q)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [1:0] d);
        dig_valid = 1'b1;
        dig       = d;
        step();
        dig_valid = 1'b0;
        dig       = 2'b00;
    endtask

    // Full conversion: start, four digits (MSB first in digs[7:6]) with gap idle cycles between them.
    task automatic conv(input logic [7:0] digs, input int gap, input logic [N:0] exp, input string tag);
        int cyc;
        cyc   = 0;
        start = 1'b1;
        step();
        cyc++;
        start = 1'b0;
        check_eq({tag, "/ready"}, 32'(dig_ready), 32'd1);
        check_eq({tag, "/busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            feed(digs[7-2*i -: 2]);
            cyc++;
            if (i < 3) begin
                check_eq({tag, "/qv_early"}, 32'(q_valid), 32'd0);
                for (int g = 0; g < gap; g++) begin
                    check_eq({tag, "/busy_gap"}, 32'(busy), 32'd1);
                    step();
                    cyc++;
                end
            end
        end
        check_eq({tag, "/q_valid"}, 32'(q_valid), 32'd1);
        check_eq({tag, "/q"}, 32'(q), 32'(exp));
        check_eq({tag, "/ready_done"}, 32'(dig_ready), 32'd0);
        check_eq({tag, "/busy_done"}, 32'(busy), 32'd0);
        if (gap == 0) check_eq({tag, "/latency"}, 32'(cyc), 32'd5);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        dig_valid = 1'b0;
        dig       = 2'b00;
        step();
        step();
        check_eq("rst/ready", 32'(dig_ready), 32'd0);
        check_eq("rst/busy", 32'(busy), 32'd0);
        check_eq("rst/q_valid", 32'(q_valid), 32'd0);
        check_eq("rst/q", 32'(q), 32'd0);
        rst = 1'b0;
        step();

        conv({P1, Z0, M1, P1}, 0, 5'b00111, "p7");
        conv({M1, M1, M1, M1}, 0, 5'b10001, "m15");
        conv({P1, P2, P2, P1}, 0, 5'b01111, "p15mix");
        conv({P1, M1, M1, M1}, 0, 5'b00001, "p1");
        conv({Z0, Z0, Z0, M1}, 0, 5'b11111, "m1");
        conv({P1, Z0, M1, P1}, 3, 5'b00111, "p7gap");

        // DONE holds and ignores digits while start is low.
        dig_valid = 1'b1;
        dig       = P1;
        step();
        step();
        dig_valid = 1'b0;
        check_eq("hold/q_valid", 32'(q_valid), 32'd1);
        check_eq("hold/q", 32'(q), 32'd7);

        // start during CONV is ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        feed(P1);
        feed(Z0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("midstart/busy", 32'(busy), 32'd1);
        check_eq("midstart/ready", 32'(dig_ready), 32'd1);
        feed(M1);
        check_eq("midstart/qv_early", 32'(q_valid), 32'd0);
        feed(P2);
        check_eq("midstart/q_valid", 32'(q_valid), 32'd1);
        check_eq("midstart/q", 32'(q), 32'd7);

        // Reset mid-conversion discards progress.
        start = 1'b1;
        step();
        start = 1'b0;
        feed(M1);
        feed(M1);
        rst       = 1'b1;
        dig_valid = 1'b1;
        dig       = M1;
        step();
        rst       = 1'b0;
        dig_valid = 1'b0;
        check_eq("midrst/ready", 32'(dig_ready), 32'd0);
        check_eq("midrst/busy", 32'(busy), 32'd0);
        check_eq("midrst/q_valid", 32'(q_valid), 32'd0);
        check_eq("midrst/q", 32'(q), 32'd0);
        conv({P1, P1, M1, Z0}, 0, 5'b01010, "p10");

        // Restart from DONE: q_valid drops next cycle; a digit alongside start is not accepted.
        conv({P1, Z0, M1, P1}, 0, 5'b00111, "p7b");
        start     = 1'b1;
        dig_valid = 1'b1;
        dig       = M1;
        step();
        start     = 1'b0;
        dig_valid = 1'b0;
        check_eq("restart/q_valid", 32'(q_valid), 32'd0);
        check_eq("restart/q", 32'(q), 32'd0);
        feed(Z0);
        feed(Z0);
        feed(Z0);
        check_eq("zero/qv_early", 32'(q_valid), 32'd0);
        feed(Z0);
        check_eq("zero/q_valid", 32'(q_valid), 32'd1);
        check_eq("zero/q", 32'(q), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
